// File: rtl/serial_subtract_if.sv
// Operand/result bundle for the bit-serial subtractor; the master drives
// start and the operands, the slave returns status and the result.
interface serial_subtract_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtract.sv
// Bit-serial full subtractor: A - B - Bin, one bit per clock, LSB first,
// with a single borrow flip-flop chaining the bits together.
module serial_subtract #(
    parameter int unsigned WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    serial_subtract_if.slave sub
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             d_bit;
    logic             brw_nxt;
    logic [WIDTH-1:0] diff_sr_nxt;

    always_comb begin
        d_bit       = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
        brw_nxt     = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & brw_q);
        diff_sr_nxt = {d_bit, diff_sr_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        diff_sr_d = diff_sr_q;
        diff_d    = diff_q;
        cnt_d     = cnt_q;
        brw_d     = brw_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        bout_d    = bout_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (sub.start) begin
                    a_sr_d    = sub.a;
                    b_sr_d    = sub.b;
                    brw_d     = sub.bin;
                    a_msb_d   = sub.a[WIDTH-1];
                    b_msb_d   = sub.b[WIDTH-1];
                    diff_sr_d = '0;
                    cnt_d     = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                a_sr_d    = a_sr_q >> 1;
                b_sr_d    = b_sr_q >> 1;
                brw_d     = brw_nxt;
                diff_sr_d = diff_sr_nxt;
                cnt_d     = cnt_q + 1'b1;
                // Result registers only move on the final bit, so they hold across a new run.
                if (cnt_q == LAST) begin
                    diff_d  = diff_sr_nxt;
                    bout_d  = brw_nxt;
                    ovf_d   = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            diff_sr_q <= '0;
            diff_q    <= '0;
            cnt_q     <= '0;
            brw_q     <= 1'b0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            bout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            diff_sr_q <= diff_sr_d;
            diff_q    <= diff_d;
            cnt_q     <= cnt_d;
            brw_q     <= brw_d;
            a_msb_q   <= a_msb_d;
            b_msb_q   <= b_msb_d;
            bout_q    <= bout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign sub.busy = (state_q == S_RUN);
    assign sub.done = (state_q == S_DONE);
    assign sub.diff = diff_q;
    assign sub.bout = bout_q;
    assign sub.ovf  = ovf_q;
endmodule
